// File: rtl/stim_sequencer.sv
// Scripted KEY/SW stimulus player for vga_demo: replays timed, active-low key presses and switch settings.
// Optional feature macro: STIM_LOOP_EN (when defined, loop=1 replays the script from entry 0 indefinitely).
module stim_sequencer #(
  parameter int NUM_KEYS = 4,
  parameter int SW_W     = 10,
  parameter int DEPTH    = 8,
  parameter int DELAY_W  = 16
) (
  input  logic                                  CLOCK_50,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  logic [$clog2(DEPTH)-1:0]              wr_addr,
  input  logic [SW_W+NUM_KEYS+2*DELAY_W-1:0]    wr_data,
  input  logic [$clog2(DEPTH):0]                script_len,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  loop,
  output logic [NUM_KEYS-1:0]                   KEY,
  output logic [SW_W-1:0]                       SW,
  output logic                                  busy,
  output logic                                  done,
  output logic [$clog2(DEPTH)-1:0]              cur_idx
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LEN_W   = IDX_W + 1;
  localparam int ENTRY_W = SW_W + NUM_KEYS + 2 * DELAY_W;

`ifdef STIM_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic logic [DELAY_W-1:0] f_gap(input logic [ENTRY_W-1:0] e);
    return e[DELAY_W-1:0];
  endfunction

  // A zero hold still produces a one-cycle press.
  function automatic logic [DELAY_W-1:0] f_hold(input logic [ENTRY_W-1:0] e);
    logic [DELAY_W-1:0] h;
    h = e[2*DELAY_W-1:DELAY_W];
    return (h == {DELAY_W{1'b0}}) ? DELAY_W'(1) : h;
  endfunction

  function automatic logic [NUM_KEYS-1:0] f_mask(input logic [ENTRY_W-1:0] e);
    return e[2*DELAY_W+NUM_KEYS-1:2*DELAY_W];
  endfunction

  function automatic logic [SW_W-1:0] f_sw(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-1:2*DELAY_W+NUM_KEYS];
  endfunction

  logic [ENTRY_W-1:0]  mem_r [DEPTH];
  state_t              state_r, state_nxt_s;
  logic [DELAY_W-1:0]  cnt_r, cnt_nxt_s;
  logic [NUM_KEYS-1:0] key_r, key_nxt_s;
  logic [SW_W-1:0]     sw_r, sw_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic [IDX_W-1:0]    idx_r, idx_nxt_s;
  logic [LEN_W-1:0]    len_r, len_nxt_s;
  logic [LEN_W-1:0]    idx_p1_s;
  logic                last_s;
  logic                load_s;
  logic [IDX_W-1:0]    load_idx_s;
  logic [ENTRY_W-1:0]  load_entry_s;
  logic [ENTRY_W-1:0]  cur_entry_s;

  assign idx_p1_s     = {1'b0, idx_r} + LEN_W'(1);
  assign last_s       = (idx_p1_s >= len_r);
  assign load_idx_s   = ((state_r == HOLD) && !last_s) ? idx_p1_s[IDX_W-1:0] : {IDX_W{1'b0}};
  assign load_entry_s = mem_r[load_idx_s];
  assign cur_entry_s  = mem_r[idx_r];

  // Script memory: writable only while idle, never cleared by reset.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !busy_r) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic for the playback FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    key_nxt_s   = key_r;
    sw_nxt_s    = sw_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    idx_nxt_s   = idx_r;
    len_nxt_s   = len_r;
    load_s      = 1'b0;

    if (stop && (state_r != IDLE)) begin
      state_nxt_s = IDLE;
      key_nxt_s   = {NUM_KEYS{1'b1}};
      busy_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            if (script_len != {LEN_W{1'b0}}) begin
              len_nxt_s  = script_len;
              busy_nxt_s = 1'b1;
              idx_nxt_s  = {IDX_W{1'b0}};
              load_s     = 1'b1;
            end else begin
              done_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        GAP: begin
          if (cnt_r <= DELAY_W'(1)) begin
            state_nxt_s = HOLD;
            cnt_nxt_s   = f_hold(cur_entry_s);
            key_nxt_s   = ~f_mask(cur_entry_s);
            sw_nxt_s    = f_sw(cur_entry_s);
          end else begin
            cnt_nxt_s = cnt_r - DELAY_W'(1);
          end
        end
        HOLD: begin
          if (cnt_r <= DELAY_W'(1)) begin
            key_nxt_s = {NUM_KEYS{1'b1}};
            if (!last_s) begin
              idx_nxt_s = idx_p1_s[IDX_W-1:0];
              load_s    = 1'b1;
            end else if (LOOP_EN && loop) begin
              idx_nxt_s = {IDX_W{1'b0}};
              load_s    = 1'b1;
            end else begin
              state_nxt_s = FINISH;
            end
          end else begin
            cnt_nxt_s = cnt_r - DELAY_W'(1);
          end
        end
        FINISH: begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end
        default: begin
          state_nxt_s = IDLE;
          key_nxt_s   = {NUM_KEYS{1'b1}};
          busy_nxt_s  = 1'b0;
        end
      endcase
    end

    // Starting an entry with no gap presses its keys at the same edge.
    if (load_s) begin
      if (f_gap(load_entry_s) == {DELAY_W{1'b0}}) begin
        state_nxt_s = HOLD;
        cnt_nxt_s   = f_hold(load_entry_s);
        key_nxt_s   = ~f_mask(load_entry_s);
        sw_nxt_s    = f_sw(load_entry_s);
      end else begin
        state_nxt_s = GAP;
        cnt_nxt_s   = f_gap(load_entry_s);
        key_nxt_s   = {NUM_KEYS{1'b1}};
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {DELAY_W{1'b0}};
      key_r   <= {NUM_KEYS{1'b1}};
      sw_r    <= {SW_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      len_r   <= {LEN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      key_r   <= key_nxt_s;
      sw_r    <= sw_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      idx_r   <= idx_nxt_s;
      len_r   <= len_nxt_s;
    end
  end

  assign KEY     = key_r;
  assign SW      = sw_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign cur_idx = idx_r;

endmodule

// File: tb/tb_stim_sequencer.sv
// Scoreboard bench for stim_sequencer: every change of {KEY,SW,busy,done,cur_idx} is matched to a queued expected event.
module tb_stim_sequencer;
  localparam int NK = 4, SWW = 10, DEP = 8, DW = 16, IW = 3, LW = 4;
  localparam int EW = SWW + NK + 2 * DW;

  logic          clk = 1'b0, reset = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [EW-1:0] wr_data = '0;
  logic [LW-1:0] script_len = '0;
  logic [NK-1:0] KEY;
  logic [SWW-1:0] SW;
  logic          busy, done;
  logic [IW-1:0] cur_idx;

  stim_sequencer #(.NUM_KEYS(NK), .SW_W(SWW), .DEPTH(DEP), .DELAY_W(DW)) dut (
    .CLOCK_50(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .script_len(script_len), .start(start), .stop(stop), .loop(loop),
    .KEY(KEY), .SW(SW), .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; logic [18:0] v; } ev_t;
  ev_t q[$];
  int  checks = 0, errors = 0, base = 0;

  function automatic logic [18:0] pk(logic [3:0] k, logic [9:0] s, logic b, logic d, logic [2:0] i);
    return {k, s, b, d, i};
  endfunction

  function automatic logic [EW-1:0] ent(logic [9:0] s, logic [3:0] m, logic [15:0] h, logic [15:0] g);
    return {s, m, h, g};
  endfunction

  task automatic ex(input int rel, input logic [3:0] k, input logic [9:0] s, input logic b,
                    input logic d, input logic [2:0] i);
    ev_t e;
    e.t = base + rel;
    e.v = pk(k, s, b, d, i);
    q.push_back(e);
  endtask

  task automatic wr(input logic [IW-1:0] a, input logic [EW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic arm(input logic [LW-1:0] len);
    @(negedge clk);
    base = cyc;
    script_len = len;
  endtask

  task automatic fire();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int rel);
    while (cyc < base + rel) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events still pending, required 0", q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: any output change must match the next expected event, in value and cycle.
  initial begin
    logic [18:0] prev, cur;
    ev_t me;
    prev = pk(4'hF, 10'h000, 1'b0, 1'b0, 3'd0);
    forever begin
      @(negedge clk);
      cur = {KEY, SW, busy, done, cur_idx};
      if (reset) begin
        prev = cur;
      end else if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: t=%0d got=%h, required no change", cyc - base, cur);
        end else begin
          me = q.pop_front();
          if (me.t != cyc || me.v !== cur) begin
            errors++;
            $display("FAIL event: got t=%0d val=%h, required t=%0d val=%h", cyc - base, cur, me.t - base, me.v);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({KEY, SW, busy, done, cur_idx} !== pk(4'hF, 10'h000, 1'b0, 1'b0, 3'd0)) begin
      errors++;
      $display("FAIL reset_state: got=%h required=%h", {KEY, SW, busy, done, cur_idx}, pk(4'hF, 10'h000, 1'b0, 1'b0, 3'd0));
    end

    // Default-style replay: gap 0 then gap 8, single-cycle presses
    wr(3'd0, ent(10'h048, 4'b0001, 16'd1, 16'd0));
    wr(3'd1, ent(10'h048, 4'b0010, 16'd1, 16'd8));
    arm(4'd2);
    ex(1,  4'hE, 10'h048, 1'b1, 1'b0, 3'd0);
    ex(2,  4'hF, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(10, 4'hD, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(11, 4'hF, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(12, 4'hF, 10'h048, 1'b0, 1'b1, 3'd1);
    ex(13, 4'hF, 10'h048, 1'b0, 1'b0, 3'd1);
    fire();
    drain(40);

    // Multi-key press with hold=0 clamped to one cycle
    wr(3'd0, ent(10'h123, 4'b1010, 16'd0, 16'd3));
    arm(4'd1);
    ex(1, 4'hF, 10'h048, 1'b1, 1'b0, 3'd0);
    ex(4, 4'h5, 10'h123, 1'b1, 1'b0, 3'd0);
    ex(5, 4'hF, 10'h123, 1'b1, 1'b0, 3'd0);
    ex(6, 4'hF, 10'h123, 1'b0, 1'b1, 3'd0);
    ex(7, 4'hF, 10'h123, 1'b0, 1'b0, 3'd0);
    fire();
    drain(20);

    // Abort during a long hold: no done pulse
    wr(3'd0, ent(10'h3FF, 4'b1111, 16'd50, 16'd100));
    arm(4'd2);
    ex(1,   4'hF, 10'h123, 1'b1, 1'b0, 3'd0);
    ex(101, 4'h0, 10'h3FF, 1'b1, 1'b0, 3'd0);
    ex(121, 4'hF, 10'h3FF, 1'b0, 1'b0, 3'd0);
    fire();
    wait_to(120);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain(20);

    // Replay from entry 0; start and write while busy must be ignored
    wr(3'd0, ent(10'h155, 4'b0100, 16'd2, 16'd1));
    arm(4'd2);
    ex(1,  4'hF, 10'h3FF, 1'b1, 1'b0, 3'd0);
    ex(2,  4'hB, 10'h155, 1'b1, 1'b0, 3'd0);
    ex(4,  4'hF, 10'h155, 1'b1, 1'b0, 3'd1);
    ex(12, 4'hD, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(13, 4'hF, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(14, 4'hF, 10'h048, 1'b0, 1'b1, 3'd1);
    ex(15, 4'hF, 10'h048, 1'b0, 1'b0, 3'd1);
    fire();
    wait_to(2);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = ent(10'h3FF, 4'b1111, 16'd5, 16'd5);
    start = 1'b1; script_len = 4'd0;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    drain(30);

    // Empty script: done pulse only
    arm(4'd0);
    ex(1, 4'hF, 10'h048, 1'b0, 1'b1, 3'd1);
    ex(2, 4'hF, 10'h048, 1'b0, 1'b0, 3'd1);
    fire();
    drain(10);

    // Reset mid-HOLD, then the retained script (incl. unmodified entry 1) replays
    wr(3'd0, ent(10'h2AA, 4'b0011, 16'd20, 16'd2));
    arm(4'd2);
    ex(1, 4'hF, 10'h048, 1'b1, 1'b0, 3'd0);
    ex(3, 4'hC, 10'h2AA, 1'b1, 1'b0, 3'd0);
    fire();
    wait_to(10);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({KEY, SW, busy} !== {4'hF, 10'h000, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got=%h required=%h", {KEY, SW, busy}, {4'hF, 10'h000, 1'b0});
    end
    @(negedge clk);
    #2 reset = 1'b0;
    arm(4'd2);
    ex(1,  4'hF, 10'h000, 1'b1, 1'b0, 3'd0);
    ex(3,  4'hC, 10'h2AA, 1'b1, 1'b0, 3'd0);
    ex(23, 4'hF, 10'h2AA, 1'b1, 1'b0, 3'd1);
    ex(31, 4'hD, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(32, 4'hF, 10'h048, 1'b1, 1'b0, 3'd1);
    ex(33, 4'hF, 10'h048, 1'b0, 1'b1, 3'd1);
    ex(34, 4'hF, 10'h048, 1'b0, 1'b0, 3'd1);
    fire();
    drain(60);

    // loop=1: repeats every 8 cycles with the feature, ignored without it
    wr(3'd0, ent(10'h011, 4'b0001, 16'd2, 16'd2));
    wr(3'd1, ent(10'h022, 4'b1000, 16'd2, 16'd2));
    loop = 1'b1;
    arm(4'd2);
    ex(1, 4'hF, 10'h048, 1'b1, 1'b0, 3'd0);
`ifdef STIM_LOOP_EN
    for (int k = 0; k < 3; k++) begin
      ex(3 + 8 * k, 4'hE, 10'h011, 1'b1, 1'b0, 3'd0);
      ex(5 + 8 * k, 4'hF, 10'h011, 1'b1, 1'b0, 3'd1);
      ex(7 + 8 * k, 4'h7, 10'h022, 1'b1, 1'b0, 3'd1);
      ex(9 + 8 * k, 4'hF, 10'h022, 1'b1, 1'b0, 3'd0);
    end
    ex(27, 4'hF, 10'h022, 1'b0, 1'b0, 3'd0);
    fire();
    wait_to(26);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    drain(40);
`else
    ex(3,  4'hE, 10'h011, 1'b1, 1'b0, 3'd0);
    ex(5,  4'hF, 10'h011, 1'b1, 1'b0, 3'd1);
    ex(7,  4'h7, 10'h022, 1'b1, 1'b0, 3'd1);
    ex(9,  4'hF, 10'h022, 1'b1, 1'b0, 3'd1);
    ex(10, 4'hF, 10'h022, 1'b0, 1'b1, 3'd1);
    ex(11, 4'hF, 10'h022, 1'b0, 1'b0, 3'd1);
    fire();
    drain(30);
`endif
    loop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
